// File: rtl/sop_table_eval.sv
// Multi-channel programmable truth-table evaluator with a built-in equivalence sweep against channel 0.
// Optional build macro: SOP_TABLE_EVAL_STOP_ON_MISMATCH_EN ends the sweep at the first mismatching index.
module sop_table_eval #(
  parameter int N_IN = 4,
  parameter int N_CH = 2,
  parameter logic [2**N_IN-1:0] RESET_TABLE = 16'h551F,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_bit,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  output logic [N_CH-1:0] out_vec,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            any_mism,
  output logic [N_IN:0]   mism_cnt,
  output logic [N_IN-1:0] first_idx
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  state_t                state;
  logic [N_IN-1:0]       idx;
  logic [2**N_IN-1:0]    tbl [N_CH];
  logic                  mism;
  logic                  sweep_end;

  // Channel 0 is the reference; with a single channel nothing can mismatch.
  always_comb begin
    mism = 1'b0;
    for (int c = 1; c < N_CH; c++) begin
      if (tbl[c][idx] != tbl[0][idx]) mism = 1'b1;
    end
  end

`ifdef SOP_TABLE_EVAL_STOP_ON_MISMATCH_EN
  assign sweep_end = (idx == IDX_LAST) || mism;
`else
  assign sweep_end = (idx == IDX_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      any_mism  <= 1'b0;
      mism_cnt  <= '0;
      first_idx <= '0;
      for (int c = 0; c < N_CH; c++) tbl[c] <= RESET_TABLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Non-blocking write: an evaluation of the same address this cycle reads the old bit.
          if (cfg_we && (int'(cfg_ch) < N_CH)) tbl[cfg_ch][cfg_addr] <= cfg_bit;
          out_valid <= in_valid;
          if (in_valid) begin
            for (int c = 0; c < N_CH; c++) out_vec[c] <= tbl[c][in_vec];
          end
          if (start) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            done      <= 1'b0;
            idx       <= '0;
            any_mism  <= 1'b0;
            mism_cnt  <= '0;
            first_idx <= '0;
          end
        end
        SWEEP: begin
          out_valid <= 1'b0;
          if (mism) begin
            mism_cnt <= mism_cnt + 1'b1;
            any_mism <= 1'b1;
            if (!any_mism) first_idx <= idx;
          end
          idx <= idx + 1'b1;
          if (sweep_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sop_table_eval.sv
// Bench for sop_table_eval: table-driven evaluation vectors, a scoreboard queue for evaluation results,
// and hand-written sweep sequences (plain, disturbed, reset mid-sweep).
module tb_sop_table_eval;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [0:0] cfg_ch;
  logic [3:0] cfg_addr;
  logic       cfg_bit;
  logic       in_valid;
  logic [3:0] in_vec;
  logic       out_valid;
  logic [1:0] out_vec;
  logic       start;
  logic       busy;
  logic       done;
  logic       any_mism;
  logic [4:0] mism_cnt;
  logic [3:0] first_idx;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_q[$];
  logic [15:0] mdl [2];

  typedef struct {
    logic [3:0] vec;
    logic [1:0] exp;
  } vec_t;
  vec_t vectors [16];

  sop_table_eval dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit),
    .in_valid(in_valid), .in_vec(in_vec),
    .out_valid(out_valid), .out_vec(out_vec),
    .start(start), .busy(busy), .done(done),
    .any_mism(any_mism), .mism_cnt(mism_cnt), .first_idx(first_idx)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl[0] = 16'h551F;
    mdl[1] = 16'h551F;
  endtask

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic cfg_write(input logic ch, input logic [3:0] addr, input logic b);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_bit = b;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mdl[ch][addr] = b;
  endtask

  task automatic eval(input logic [3:0] v, input logic [1:0] exp);
    in_valid = 1'b1; in_vec = v;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [1:0] model_out(input logic [3:0] v);
    return {mdl[1][v], mdl[0][v]};
  endfunction

  task automatic run_sweep(input int exp_cyc, input int exp_cnt, input int exp_first,
                           input bit exp_any, input bit disturb);
    int k;
    bit seen;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    k = 0;
    seen = 0;
    while (k < 40 && !seen) begin
      if (disturb && k == 4) begin
        start = 1'b1;
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_addr = 4'd3; cfg_bit = ~mdl[1][3];
        in_valid = 1'b1; in_vec = 4'd3;
      end
      @(posedge clk); #1;
      k++;
      if (disturb && k == 5) begin
        start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
      end
      if (done) seen = 1;
      else if (busy !== 1'b1) chk("busy_during_sweep", busy, 1);
    end
    chk("sweep_timeout", seen, 1);
    chk("sweep_cycles", k, exp_cyc);
    chk("busy_at_done", busy, 0);
    chk("mism_cnt", mism_cnt, exp_cnt);
    chk("first_idx", first_idx, exp_first);
    chk("any_mism", any_mism, exp_any);
    repeat (2) @(posedge clk);
    #1 chk("done_held", done, 1);
  endtask

  // Scoreboard: every fresh result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got out_vec %0h expected no result", out_vec);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (out_vec !== e) begin
          errors++;
          $display("FAIL out_vec: got %0h expected %0h", out_vec, e);
        end
      end
    end
  end

  initial begin
    int n_mism;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_vec = '0; start = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vectors[i].vec = 4'(i);
      vectors[i].exp = (i <= 4 || i == 8 || i == 10 || i == 12 || i == 14) ? 2'b11 : 2'b00;
    end

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_any_mism", any_mism, 0);
    chk("rst_mism_cnt", mism_cnt, 0);
    chk("rst_first_idx", first_idx, 0);

    // Reset truth table, one vector per cycle back to back.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_vec = vectors[i].vec;
      exp_q.push_back(vectors[i].exp);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_vec = 4'd14; exp_q.push_back(2'b11);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_vec_hold", out_vec, 2'b11);

    run_sweep(16, 0, 0, 0, 0);

    // Write and evaluate the same address in one cycle: old bit is seen.
    in_valid = 1'b1; in_vec = 4'd5; exp_q.push_back(2'b00);
    cfg_write(1'b1, 4'd5, 1'b1);
    in_valid = 1'b0;
    eval(4'd5, 2'b10);
    `ifdef SOP_TABLE_EVAL_STOP_ON_MISMATCH_EN
      run_sweep(6, 1, 5, 1, 0);
    `else
      run_sweep(16, 1, 5, 1, 0);
    `endif

    cfg_write(1'b1, 4'd9, 1'b1);
    eval(4'd9, 2'b10);
    `ifdef SOP_TABLE_EVAL_STOP_ON_MISMATCH_EN
      run_sweep(6, 1, 5, 1, 0);
    `else
      run_sweep(16, 2, 5, 1, 0);
    `endif

    // Write, evaluate and second start during the sweep are all dropped.
    `ifdef SOP_TABLE_EVAL_STOP_ON_MISMATCH_EN
      run_sweep(6, 1, 5, 1, 1);
    `else
      run_sweep(16, 2, 5, 1, 1);
    `endif
    eval(4'd3, model_out(4'd3));
    chk("table_unchanged_ch1_3", model_out(4'd3), 2'b11);

    // Random evaluations against the model.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      eval(v, model_out(v));
    end
    @(posedge clk); #1;

    // Reset in the middle of a sweep after further edits to channel 1.
    cfg_write(1'b1, 4'd0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_any_mism", any_mism, 0);
    chk("midrst_mism_cnt", mism_cnt, 0);
    chk("midrst_first_idx", first_idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl[0] = 16'h551F;
    mdl[1] = 16'h551F;
    run_sweep(16, 0, 0, 0, 0);
    eval(4'd5, 2'b00);
    eval(4'd0, 2'b11);
    eval(4'd9, 2'b00);
    repeat (2) @(posedge clk);
    #1;

    n_mism = exp_q.size();
    chk("scoreboard_drained", n_mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sop_table_eval.md
# sop_table_eval

Programmable, multi-channel sum-of-products evaluator: the successor to our fixed 4-input AND-OR / NAND-NAND function blocks. Each channel holds a 2^N_IN-entry truth table, evaluates a registered input vector with one-cycle latency, and a built-in sweep engine enumerates every input combination to prove all channels equivalent to channel 0. It sits between the lab switch/LED wrapper and the function units and replaces hard-wired gate netlists.

## Interface
- N_IN, 4, input variables per function; table depth 2^N_IN; index bit N_IN-1 is variable A (MSB).
- N_CH, 2, number of independent channels (≥1).
- RESET_TABLE, 16'h551F, reset truth table loaded into every channel; 16'h551F = A'B' + AD' + BC'D'.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write one truth-table bit.
- cfg_ch  in  max(1,$clog2(N_CH))  channel to write.
- cfg_addr  in  N_IN  minterm index to write.
- cfg_bit  in  1  value written.
- in_valid  in  1  evaluate in_vec this cycle.
- in_vec  in  N_IN  input variables.
- out_valid  out  1  out_vec holds a fresh result.
- out_vec  out  N_CH  per-channel function value.
- start  in  1  launch equivalence sweep.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete, results valid.
- any_mism  out  1  at least one mismatch found.
- mism_cnt  out  N_IN+1  number of mismatching indices.
- first_idx  out  N_IN  lowest mismatching index.

## Operation
- States: IDLE, SWEEP, DONE. Reset → IDLE.
- Reset values: all tables = RESET_TABLE; out_valid, out_vec, busy, done, any_mism, mism_cnt, first_idx all 0.
- Config write: in IDLE/DONE, cfg_we writes table[cfg_ch][cfg_addr] = cfg_bit at the edge; cfg_ch ≥ N_CH ignored. In SWEEP, writes dropped.
- Evaluate: in IDLE/DONE, in_valid samples in_vec; next cycle out_vec[c] = table[c][in_vec], out_valid = 1 for one cycle. in_valid low → out_valid 0, out_vec holds. Write and evaluate same cycle on same address: evaluation sees the old bit.
- Sweep: start in IDLE or DONE → SWEEP; idx cleared to 0, any_mism/mism_cnt/first_idx/done cleared. start in SWEEP ignored.
- SWEEP: each cycle evaluates idx; mismatch if any channel bit ≠ channel 0 bit. On mismatch mism_cnt++, any_mism = 1; first_idx captured only on first mismatch. idx increments; after idx = 2^N_IN−1 → DONE.
- DONE: done = 1, results held until next start or reset. busy = 1 exactly in SWEEP.
- in_valid during SWEEP ignored; out_valid stays 0.
- N_CH = 1: sweep always reports zero mismatches.
- mism_cnt max = 2^N_IN, fits N_IN+1 bits; no wrap.

## Timing
- Evaluate latency: 1 cycle, fully pipelined, one result per cycle.
- Sweep: start sampled at edge t; indices 0..2^N_IN−1 evaluated at edges t+1..t+2^N_IN; DONE entered and done = 1 from edge t+2^N_IN. N_IN=4: 16 cycles.
- Result registers update on the same edge that evaluates the index.
- rst asserted mid-sweep: immediate return to IDLE, tables reloaded with RESET_TABLE, all results cleared; no partial done.

## Configuration
- SOP_TABLE_EVAL_STOP_ON_MISMATCH_EN defined: sweep ends at the edge evaluating the first mismatch; DONE entered that edge with mism_cnt = 1, first_idx = that index; remaining indices not evaluated.
- Undefined (default): sweep always covers all 2^N_IN indices and counts every mismatch.

## Test plan
- Reset, in_vec = 4'b0000..4'b1111 with in_valid each cycle → out_vec = 2'b11 at indices 0,1,2,3,4,8,10,12,14, else 2'b00, each one cycle later.
- Reset, start → busy 16 cycles, done at cycle 16, any_mism = 0, mism_cnt = 0.
- Write ch1 addr 5 = 1, start → mism_cnt = 1, first_idx = 5; out_vec for in_vec = 5 is 2'b10.
- Write ch1 addr 5 = 1 and addr 9 = 1 (default build) → mism_cnt = 2, first_idx = 5; with STOP_ON_MISMATCH_EN → done at cycle 6, mism_cnt = 1.
- cfg_we and in_valid during SWEEP → table unchanged, out_valid stays 0; second start mid-sweep ignored.
- rst asserted at sweep cycle 7 after modifying ch1 → IDLE, busy/done 0, ch1 back to 16'h551F, next sweep reports 0 mismatches.
